rr_arbiter_onehot: RTL and testbench
====================================

Name: rr_arbiter_onehot

Overview:
- Registered round-robin arbiter. Samples a request vector and issues a onehot0 grant vector with a valid/ready handshake.
- Sits directly upstream of onehotIdx: o_gnt connects straight to onehotIdx i_onehot, so the output must be strictly onehot0 at all times.
- Rotating priority gives fairness: the requester granted last becomes lowest priority.
- Supports non-power-of-2 widths.

Parameters:
- WIDTH, 16, number of requesters. Legal range 2..32; non-power-of-2 values (e.g. 9) are fully supported.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rstn  input  1  reset. Synchronous, active-low; sampled on rising edge of i_clk.
- i_req  input  WIDTH  request vector; any number of bits may be set.
- o_gnt  output  WIDTH  registered grant, onehot0. Nonzero exactly when o_valid=1.
- o_valid  output  1  grant outstanding.
- i_ready  input  1  consumer accepts the grant when o_valid&&i_ready at a clock edge.

Behaviour:
- Reset (i_rstn=0 at edge):
  - o_gnt=0, o_valid=0, state=IDLE.
  - Priority pointer = bit 0, i.e. bit 0 highest, then 1, 2, ... WIDTH-1.
  - Reset asserted mid-grant discards the outstanding grant at that edge and does not advance the pointer.
- State IDLE (o_valid=0):
  - At each edge, if |i_req, select the first set bit at or above pointer p, wrapping WIDTH-1 -> 0.
  - Load o_gnt with that onehot, set o_valid=1, go to GRANT.
  - If i_req=0, stay in IDLE.
  - Latency: request present before edge N gives the grant visible after edge N (one cycle, registered). No combinational path from i_req to o_gnt.
- State GRANT (o_valid=1):
  - o_gnt and o_valid hold stable until accepted, regardless of i_req changes.
  - A requester dropping its request does not retract the grant.
- Accept (o_valid&&i_ready at edge), with k the granted index:
  - Pointer updates to (k+1) mod WIDTH. For k=WIDTH-1, pointer wraps to 0; no value >= WIDTH is ever stored.
  - The same edge arbitrates the current i_req using the new pointer.
  - If |i_req: load the new grant and stay in GRANT. Back-to-back grants: o_valid stays 1 and o_gnt changes on that edge.
  - Else: o_gnt=0, o_valid=0, go to IDLE.
  - The just-granted requester may win again only if it is the sole requester.
- i_ready while o_valid=0: ignored, no state change.
- Arbitration implementation:
  - Masked/unmasked priority select. Find-first-set on i_req & mask(p); if that is empty, find-first-set on i_req.
  - mask(p) has bits p..WIDTH-1 set.
  - Result must be onehot0 for every i_req and p.
- Unused bit positions do not exist; all vectors are exactly WIDTH bits.
- Invariants:
  - $onehot0(o_gnt) always.
  - o_valid == |o_gnt.
  - The pointer changes only on accept.

Test Plan:
1. WIDTH=16. Reset, then i_req=16'h0000 for 5 cycles -> o_valid=0, o_gnt=0 throughout; pulse i_rstn low mid-run -> outputs remain 0.
2. WIDTH=16, i_ready=1, i_req=16'hFFFF held -> grants 0001, 0002, 0004 ... 8000, then wraps to 0001. o_valid continuously 1 after the first edge. Feeding onehotIdx gives o_index 0..15,0.
3. WIDTH=9, i_ready=1, i_req=9'h1FF -> grants bits 0..8, then bit 0 again. Pointer never exceeds 8. Index sequence via onehotIdx: 0..8,0.
4. WIDTH=16, i_req=16'h0012, i_ready=0 for 4 cycles -> o_gnt=0002 held stable. Drop i_req to 0 while holding -> o_gnt still 0002. Raise i_ready -> o_valid=0 next cycle, pointer=2. Then i_req=0012 -> grant 0010.
5. WIDTH=16, after a grant of bit 15 and accept, i_req=16'h8001 -> next grant 0001 (wrap). Accept -> next grant 8000.
6. WIDTH=16, grant 0004 outstanding, assert i_rstn=0 together with i_ready=1 -> o_valid=0, o_gnt=0 after the edge. Release reset with i_req=0004 -> grant 0004 (pointer back at 0).

Source files
------------

// File: rtl/rr_arbiter_onehot.sv
// ---------------------------------------------------------------------------
// rr_arbiter_onehot
//   Registered round-robin arbiter with a valid/ready grant handshake.
//   The requester granted last becomes lowest priority on the next
//   arbitration, so every active requester is eventually served.
//   The grant vector is always onehot0 so it can drive a onehot-to-index
//   encoder directly.
//
// Parameters
//   WIDTH   : number of requesters (2..32, any value, not only powers of 2)
//
// Ports
//   i_clk   : clock, all state updates on the rising edge
//   i_rstn  : synchronous active-low reset
//   i_req   : request vector, any number of bits may be set
//   o_gnt   : registered onehot0 grant, nonzero exactly when o_valid=1
//   o_valid : grant outstanding
//   i_ready : consumer accepts the grant when o_valid && i_ready at an edge
// ---------------------------------------------------------------------------
module rr_arbiter_onehot #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_req,
  output logic [WIDTH-1:0] o_gnt,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [PW-1:0]    gnt_idx_s;
  logic [PW-1:0]    next_ptr_s;
  logic [PW-1:0]    arb_ptr_s;
  logic [WIDTH-1:0] mask_s;
  logic [WIDTH-1:0] masked_s;
  logic [WIDTH-1:0] sel_s;

  // Isolate the lowest set bit; the result is onehot0 by construction.
  function automatic logic [WIDTH-1:0] lowest_set(input logic [WIDTH-1:0] v);
    return v & (~v + WIDTH'(1));
  endfunction

  // Encode the outstanding grant to an index. The grant is onehot0, so
  // OR-ing the indices of set bits yields exactly the granted index.
  always_comb begin
    gnt_idx_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gnt_idx_s = gnt_idx_s | (gnt_q[i] ? PW'(i) : '0);
    end
  end

  // Pointer after accepting the current grant, wrapping explicitly so a
  // non-power-of-2 WIDTH never stores an out-of-range pointer.
  always_comb begin
    if (gnt_idx_s == PW'(WIDTH - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_idx_s + PW'(1);
    end
  end

  // Masked/unmasked priority select. While a grant is outstanding the only
  // edge that can load a new grant is an accept, which must already use the
  // rotated pointer, so the GRANT state always arbitrates with next_ptr_s.
  always_comb begin
    if (state_q == GRANT) begin
      arb_ptr_s = next_ptr_s;
    end else begin
      arb_ptr_s = ptr_q;
    end
    for (int i = 0; i < WIDTH; i++) begin
      mask_s[i] = (PW'(i) >= arb_ptr_s);
    end
    masked_s = i_req & mask_s;
    if (|masked_s) begin
      sel_s = lowest_set(masked_s);
    end else begin
      sel_s = lowest_set(i_req);
    end
  end

  // Next-state, next-grant and pointer update.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          gnt_d   = sel_s;
          state_d = GRANT;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (i_ready) begin
          ptr_d = next_ptr_s;
          if (|i_req) begin
            gnt_d   = sel_s;
            state_d = GRANT;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          gnt_d   = gnt_q;
          state_d = GRANT;
        end
      end
      default: begin
        gnt_d   = '0;
        ptr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and pointer registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_gnt   = gnt_q;
  assign o_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_onehot
//   Directed self-checking bench for rr_arbiter_onehot. Two instances are
//   used: WIDTH=16 and WIDTH=9 (non-power-of-2). Inputs are driven 1 time
//   unit after the rising edge and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_onehot;

  logic        clk;
  logic        rstn16, ready16, valid16;
  logic [15:0] req16, gnt16;
  logic        rstn9, ready9, valid9;
  logic [8:0]  req9, gnt9;

  int n_checks;
  int n_fail;

  rr_arbiter_onehot #(.WIDTH(16)) u_dut16 (
    .i_clk   (clk),
    .i_rstn  (rstn16),
    .i_req   (req16),
    .o_gnt   (gnt16),
    .o_valid (valid16),
    .i_ready (ready16)
  );

  rr_arbiter_onehot #(.WIDTH(9)) u_dut9 (
    .i_clk   (clk),
    .i_rstn  (rstn9),
    .i_req   (req9),
    .o_gnt   (gnt9),
    .o_valid (valid9),
    .i_ready (ready9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset16();
    rstn16 = 1'b0; req16 = 16'h0000; ready16 = 1'b0;
    tick();
    rstn16 = 1'b1;
  endtask

  task automatic reset9();
    rstn9 = 1'b0; req9 = 9'h000; ready9 = 1'b0;
    tick();
    rstn9 = 1'b1;
  endtask

  // Idle behaviour, reset values, and a reset pulse while idle.
  task automatic test_reset();
    reset16();
    n_checks++;
    if ({valid16, gnt16} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL reset_state: got v=%b g=%h, want v=0 g=0000", valid16, gnt16);
    end
    ready16 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({valid16, gnt16} !== {1'b0, 16'h0000}) begin
        n_fail++; $display("FAIL idle_cycle%0d: got v=%b g=%h, want v=0 g=0000", c, valid16, gnt16);
      end
    end
    rstn16 = 1'b0;
    tick();
    rstn16 = 1'b1;
    n_checks++;
    if ({valid16, gnt16} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL idle_rst_pulse: got v=%b g=%h, want v=0 g=0000", valid16, gnt16);
    end
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL idle_after_pulse: got v=%b g=%h, want v=0 g=0000", valid16, gnt16);
    end
  endtask

  // All 16 requesting with ready held: grants rotate 0..15 then wrap to 0.
  task automatic test_rotate16();
    logic [15:0] exp;
    reset16();
    req16 = 16'hFFFF; ready16 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp = 16'h0001 << (i % 16);
      n_checks++;
      if ({valid16, gnt16} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL rotate16_%0d: got v=%b g=%h, want v=1 g=%h", i, valid16, gnt16, exp);
      end
    end
    req16 = 16'h0000;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL rotate16_drain: got v=%b g=%h, want v=0 g=0000", valid16, gnt16);
    end
  endtask

  // WIDTH=9: grants bits 0..8 then bit 0 again.
  task automatic test_rotate9();
    logic [8:0] exp;
    reset9();
    n_checks++;
    if ({valid9, gnt9} !== {1'b0, 9'h000}) begin
      n_fail++; $display("FAIL reset9_state: got v=%b g=%h, want v=0 g=000", valid9, gnt9);
    end
    req9 = 9'h1FF; ready9 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = 9'h001 << (i % 9);
      n_checks++;
      if ({valid9, gnt9} !== {1'b1, exp}) begin
        n_fail++; $display("FAIL rotate9_%0d: got v=%b g=%h, want v=1 g=%h", i, valid9, gnt9, exp);
      end
    end
    // Only bits 8 and 0 request after granting 0: pointer=1 -> 8, then wrap -> 0.
    req9 = 9'h101;
    tick();
    n_checks++;
    if ({valid9, gnt9} !== {1'b1, 9'h100}) begin
      n_fail++; $display("FAIL rotate9_hi: got v=%b g=%h, want v=1 g=100", valid9, gnt9);
    end
    tick();
    n_checks++;
    if ({valid9, gnt9} !== {1'b1, 9'h001}) begin
      n_fail++; $display("FAIL rotate9_wrap: got v=%b g=%h, want v=1 g=001", valid9, gnt9);
    end
    req9 = 9'h000;
    tick();
  endtask

  // Grant held while not accepted, even when the request drops.
  task automatic test_hold();
    reset16();
    req16 = 16'h0012; ready16 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({valid16, gnt16} !== {1'b1, 16'h0002}) begin
        n_fail++; $display("FAIL hold_%0d: got v=%b g=%h, want v=1 g=0002", c, valid16, gnt16);
      end
    end
    req16 = 16'h0000;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h0002}) begin
      n_fail++; $display("FAIL hold_req_drop: got v=%b g=%h, want v=1 g=0002", valid16, gnt16);
    end
    ready16 = 1'b1;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL hold_accept_idle: got v=%b g=%h, want v=0 g=0000", valid16, gnt16);
    end
    ready16 = 1'b0; req16 = 16'h0012;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h0010}) begin
      n_fail++; $display("FAIL hold_next_rr: got v=%b g=%h, want v=1 g=0010", valid16, gnt16);
    end
    ready16 = 1'b1; req16 = 16'h0000;
    tick();
  endtask

  // Pointer wrap after granting bit 15, and sole-requester re-grant.
  task automatic test_wrap();
    reset16();
    req16 = 16'h8000; ready16 = 1'b0;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h8000}) begin
      n_fail++; $display("FAIL wrap_first: got v=%b g=%h, want v=1 g=8000", valid16, gnt16);
    end
    req16 = 16'h8001; ready16 = 1'b1;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h0001}) begin
      n_fail++; $display("FAIL wrap_to0: got v=%b g=%h, want v=1 g=0001", valid16, gnt16);
    end
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h8000}) begin
      n_fail++; $display("FAIL wrap_back: got v=%b g=%h, want v=1 g=8000", valid16, gnt16);
    end
    req16 = 16'h8000;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h8000}) begin
      n_fail++; $display("FAIL wrap_sole: got v=%b g=%h, want v=1 g=8000", valid16, gnt16);
    end
    req16 = 16'h0000;
    tick();
  endtask

  // Reset mid-grant discards the grant and returns the pointer to 0.
  task automatic test_reset_mid_grant();
    reset16();
    req16 = 16'h0004; ready16 = 1'b0;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h0004}) begin
      n_fail++; $display("FAIL rmid_grant: got v=%b g=%h, want v=1 g=0004", valid16, gnt16);
    end
    rstn16 = 1'b0; ready16 = 1'b1;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL rmid_cleared: got v=%b g=%h, want v=0 g=0000", valid16, gnt16);
    end
    rstn16 = 1'b1; ready16 = 1'b0; req16 = 16'h0004;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h0004}) begin
      n_fail++; $display("FAIL rmid_regrant: got v=%b g=%h, want v=1 g=0004", valid16, gnt16);
    end
    // Accept bit 2 (pointer -> 3), then reset: bit 2 must win over bit 3.
    ready16 = 1'b1; req16 = 16'h0000;
    tick();
    rstn16 = 1'b0; ready16 = 1'b0;
    tick();
    rstn16 = 1'b1; req16 = 16'h000C;
    tick();
    n_checks++;
    if ({valid16, gnt16} !== {1'b1, 16'h0004}) begin
      n_fail++; $display("FAIL rmid_ptr_zero: got v=%b g=%h, want v=1 g=0004", valid16, gnt16);
    end
    ready16 = 1'b1; req16 = 16'h0000;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rstn16 = 1'b0; req16 = 16'h0000; ready16 = 1'b0;
    rstn9  = 1'b0; req9  = 9'h000;   ready9  = 1'b0;
    #1;
    test_reset();
    test_rotate16();
    test_rotate9();
    test_hold();
    test_wrap();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
